// File: rtl/present_enc_ctrl.sv
// Sequencing controller for an external iterative PRESENT-80 encryptor core.
// Accepts one key/plaintext request at a time and presents the ciphertext on a valid/ready output.
module present_enc_ctrl #(
   parameter int NUM_ROUNDS = 31
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [79:0] in_key_i,
   input  logic [63:0] in_pt_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] out_ct_o,
   output logic [79:0] core_din_o,
   output logic        core_key_load_o,
   output logic        core_data_load_o,
   input  logic [63:0] core_dout_i,
   output logic        busy_o
);

   typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_DATA, RUN, CAPTURE} state_t;

   localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [79:0] key_q, key_d;
   logic [63:0] pt_q, pt_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] out_ct_q, out_ct_d;
   logic        in_ready;
   logic        key_load;
   logic        data_load;
   logic [79:0] din;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= 5'd0;
         key_q       <= 80'h0;
         pt_q        <= 64'h0;
         out_valid_q <= 1'b0;
         out_ct_q    <= 64'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         pt_q        <= pt_d;
         out_valid_q <= out_valid_d;
         out_ct_q    <= out_ct_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      pt_d        = pt_q;
      out_valid_d = out_valid_q;
      out_ct_d    = out_ct_q;
      key_load    = 1'b0;
      data_load   = 1'b0;
      din         = 80'h0;
      in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready_i);

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (in_valid_i && in_ready) begin
               key_d   = in_key_i;
               pt_d    = in_pt_i;
               state_d = LOAD_KEY;
            end
         end
         // The core clobbers its key register while running, so every request reloads it.
         LOAD_KEY: begin
            key_load = 1'b1;
            din      = key_q;
            state_d  = LOAD_DATA;
         end
         LOAD_DATA: begin
            data_load = 1'b1;
            din       = {16'h0, pt_q};
            cnt_d     = 5'd0;
            state_d   = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            out_ct_d    = core_dout_i;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Core-facing strobes are forced quiet while reset is held, whatever the old state was.
   assign core_key_load_o  = key_load && rst_ni;
   assign core_data_load_o = data_load && rst_ni;
   assign core_din_o       = din & {80{rst_ni}};
   assign busy_o           = rst_ni && (state_q != IDLE);
   assign in_ready_o       = in_ready || !rst_ni;
   assign out_valid_o      = out_valid_q;
   assign out_ct_o         = out_ct_q;

endmodule
